// File: rtl/gpio_pkg.sv
// Shared definitions for the iomem GPIO block: register indices and a
// byte-strobe expansion helper.
package gpio_pkg;

  typedef enum logic [2:0] {
    RegOut     = 3'd0,
    RegOe      = 3'd1,
    RegIn      = 3'd2,
    RegSet     = 3'd3,
    RegClr     = 3'd4,
    RegIrqEn   = 3'd5,
    RegIrqStat = 3'd6,
    RegIrqEdge = 3'd7
  } gpio_reg_e;

  // Expand the four byte strobes into a 32-bit bit mask.
  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{strb[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/iomem_gpio_if.sv
// PicoRV32-style iomem bus bundle; the CPU side is master, peripherals are slave.
interface iomem_gpio_if;

  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid,
    output iomem_wstrb,
    output iomem_addr,
    output iomem_wdata,
    input  iomem_ready,
    input  iomem_rdata
  );

  modport slave (
    input  iomem_valid,
    input  iomem_wstrb,
    input  iomem_addr,
    input  iomem_wdata,
    output iomem_ready,
    output iomem_rdata
  );

endinterface

// File: rtl/gpio_sync_edge.sv
// Pin input synchroniser with per-bit edge detection; edges are held off until
// the synchroniser has flushed after reset so pins already high are not seen.
module gpio_sync_edge #(
  parameter int unsigned WIDTH       = 11,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] gpio_in,
  input  logic [WIDTH-1:0] edge_rise,
  output logic [WIDTH-1:0] sync_val,
  output logic [WIDTH-1:0] edge_pulse
);

  localparam logic [2:0] ArmCount = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [2:0]       arm_q, arm_d;
  logic             armed;
  logic [WIDTH-1:0] rise_ev, fall_ev;

  always_comb begin
    sync_d[0] = gpio_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign sync_val = sync_q[SYNC_STAGES-1];
  assign prev_d   = sync_val;

  // Counts cycles since reset release; saturates once the chain holds real data.
  assign armed = (arm_q == ArmCount);
  assign arm_d = armed ? arm_q : arm_q + 3'd1;

  always_comb begin
    rise_ev    = sync_val & ~prev_q & edge_rise;
    fall_ev    = ~sync_val & prev_q & ~edge_rise;
    edge_pulse = armed ? (rise_ev | fall_ev) : '0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q <= '0;
      arm_q  <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      prev_q <= prev_d;
      arm_q  <= arm_d;
    end
  end

endmodule

// File: rtl/iomem_gpio.sv
// Memory-mapped GPIO peripheral on the iomem bus: output/enable registers,
// atomic set/clear, synchronised inputs and edge interrupts.
module iomem_gpio
  import gpio_pkg::*;
#(
  parameter int unsigned WIDTH       = 11,
  parameter logic [7:0]  BASE_SEL    = 8'h03,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  iomem_gpio_if.slave      bus,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  input  logic [WIDTH-1:0] gpio_in,
  output logic             irq
);

  logic             ready_q, ready_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] oe_q, oe_d;
  logic [WIDTH-1:0] en_q, en_d;
  logic [WIDTH-1:0] stat_q, stat_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic             irq_q, irq_d;

  logic             sel, wr;
  gpio_reg_e        idx;
  logic [31:0]      lane_m;
  logic [WIDTH-1:0] wmask, wbits, w1c;
  logic [WIDTH-1:0] sync_val, edge_pulse;
  logic             unused_bits;

  gpio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk        (clk),
    .resetn     (resetn),
    .gpio_in    (gpio_in),
    .edge_rise  (edge_q),
    .sync_val   (sync_val),
    .edge_pulse (edge_pulse)
  );

  // Blocking on ready_q keeps a held valid from being accepted twice.
  assign sel    = bus.iomem_valid && !ready_q && (bus.iomem_addr[31:24] == BASE_SEL);
  assign wr     = sel && (|bus.iomem_wstrb);
  assign idx    = gpio_reg_e'(bus.iomem_addr[4:2]);
  assign lane_m = strb_mask(bus.iomem_wstrb);
  assign wmask  = lane_m[WIDTH-1:0];
  assign wbits  = bus.iomem_wdata[WIDTH-1:0] & wmask;

  assign unused_bits = ^{bus.iomem_addr[23:5], bus.iomem_addr[1:0], bus.iomem_wdata, lane_m};

  always_comb begin
    out_d   = out_q;
    oe_d    = oe_q;
    en_d    = en_q;
    edge_d  = edge_q;
    w1c     = '0;
    rdata_d = '0;
    ready_d = sel;

    if (sel) begin
      unique case (idx)
        RegOut:     rdata_d = 32'(out_q);
        RegOe:      rdata_d = 32'(oe_q);
        RegIn:      rdata_d = 32'(sync_val);
        RegIrqEn:   rdata_d = 32'(en_q);
        RegIrqStat: rdata_d = 32'(stat_q);
        RegIrqEdge: rdata_d = 32'(edge_q);
        default:    rdata_d = '0;
      endcase
    end

    if (wr) begin
      unique case (idx)
        RegOut:     out_d  = (out_q & ~wmask) | wbits;
        RegOe:      oe_d   = (oe_q & ~wmask) | wbits;
        RegSet:     out_d  = out_q | wbits;
        RegClr:     out_d  = out_q & ~wbits;
        RegIrqEn:   en_d   = (en_q & ~wmask) | wbits;
        RegIrqStat: w1c    = wbits;
        RegIrqEdge: edge_d = (edge_q & ~wmask) | wbits;
        default:    ;
      endcase
    end

    // A fresh edge in the same cycle as a clear keeps the bit set.
    stat_d = (stat_q & ~w1c) | edge_pulse;
    irq_d  = |(stat_q & en_q);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      out_q   <= '0;
      oe_q    <= '0;
      en_q    <= '0;
      stat_q  <= '0;
      edge_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      out_q   <= out_d;
      oe_q    <= oe_d;
      en_q    <= en_d;
      stat_q  <= stat_d;
      edge_q  <= edge_d;
      irq_q   <= irq_d;
    end
  end

  assign bus.iomem_ready = ready_q;
  assign bus.iomem_rdata = rdata_q;
  assign gpio_out        = out_q;
  assign gpio_oe         = oe_q;
  assign irq             = irq_q;

endmodule

// File: tb/tb_iomem_gpio.sv
// Scoreboard bench for iomem_gpio: directed scenarios plus randomised traffic
// checked against a register-level reference model.
module tb_iomem_gpio;

  localparam int          W    = 11;
  localparam int          S    = 2;
  localparam logic [7:0]  BASE = 8'h03;
  localparam logic [31:0] WM   = 32'((64'd1 << W) - 64'd1);

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [W-1:0] gpio_out, gpio_oe, gpio_in;
  logic         irq;

  iomem_gpio_if bus_if ();

  iomem_gpio #(
    .WIDTH       (W),
    .BASE_SEL    (BASE),
    .SYNC_STAGES (S)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus_if),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .gpio_in  (gpio_in),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];

  // Reference model state (zero-extended to 32 bits).
  logic [31:0] m_out, m_oe, m_en, m_stat, m_edge, m_pins;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] idx);
    case (idx)
      3'd0:    return m_out;
      3'd1:    return m_oe;
      3'd2:    return m_pins & WM;
      3'd5:    return m_en;
      3'd6:    return m_stat;
      3'd7:    return m_edge;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [2:0] idx, input logic [3:0] strb,
                             input logic [31:0] wdata);
    logic [31:0] lm, wd;
    lm = 32'h0;
    for (int b = 0; b < 4; b++) if (strb[b]) lm = lm | (32'hFF << (8 * b));
    lm = lm & WM;
    wd = wdata & lm;
    case (idx)
      3'd0: m_out  = (m_out & ~lm) | wd;
      3'd1: m_oe   = (m_oe & ~lm) | wd;
      3'd3: m_out  = m_out | wd;
      3'd4: m_out  = m_out & ~wd;
      3'd5: m_en   = (m_en & ~lm) | wd;
      3'd6: m_stat = m_stat & ~wd;
      3'd7: m_edge = (m_edge & ~lm) | wd;
      default: ;
    endcase
  endtask

  // Pin transition old->new sets status for each bit moving in its selected direction.
  task automatic apply_edges(input logic [31:0] old_p, input logic [31:0] new_p);
    for (int i = 0; i < W; i++) begin
      if (old_p[i] != new_p[i] && m_edge[i] == new_p[i]) m_stat[i] = 1'b1;
    end
  endtask

  task automatic model_reset();
    m_out = 0; m_oe = 0; m_en = 0; m_stat = 0; m_edge = 0;
  endtask

  function automatic logic [31:0] model_irq();
    return (|(m_stat & m_en)) ? 32'd1 : 32'd0;
  endfunction

  // One bus access starting at posedge+1; returns two cycles later at posedge+1.
  task automatic access(input logic [2:0] idx, input logic [3:0] strb, input logic [31:0] wdata,
                        input logic [7:0] sel);
    logic hit;
    hit = (sel == BASE);
    if (hit) begin
      exp_q.push_back(model_read(idx));
      if (strb != 4'h0) model_write(idx, strb, wdata);
    end
    bus_if.iomem_addr  = {sel, 8'($urandom), 8'($urandom), 3'($urandom), idx, 2'($urandom)};
    bus_if.iomem_wstrb = strb;
    bus_if.iomem_wdata = wdata;
    bus_if.iomem_valid = 1'b1;
    @(posedge clk); #1;
    check(hit ? "ready_after_valid" : "ready_unselected", {31'b0, bus_if.iomem_ready},
          {31'b0, hit});
    bus_if.iomem_valid = 1'b0;
    bus_if.iomem_wstrb = 4'h0;
    @(posedge clk); #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_pins_irq(input string tag);
    check({tag, "_gpio_out"}, 32'(gpio_out), m_out);
    check({tag, "_gpio_oe"}, 32'(gpio_oe), m_oe);
    check({tag, "_irq"}, {31'b0, irq}, model_irq());
  endtask

  // Monitor: every ready pulse pops one expected read value.
  logic prev_ready = 1'b0;
  always @(negedge clk) begin
    if (resetn && bus_if.iomem_ready === 1'b1) begin
      check("ready_single_cycle", {31'b0, prev_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_ready: got ready=1 rdata=0x%0h required no ready",
                 bus_if.iomem_rdata);
      end else begin
        check("rdata", bus_if.iomem_rdata, exp_q.pop_front());
      end
    end
    prev_ready = (bus_if.iomem_ready === 1'b1);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] old_p, new_p;
    bus_if.iomem_valid = 1'b0;
    bus_if.iomem_wstrb = 4'h0;
    bus_if.iomem_addr  = 32'h0;
    bus_if.iomem_wdata = 32'h0;
    gpio_in = '0;
    m_pins  = 0;
    model_reset();

    // Reset state
    @(posedge clk); #1;
    cycles(3);
    check("rst_gpio_out", 32'(gpio_out), 32'h0);
    check("rst_gpio_oe", 32'(gpio_oe), 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_ready", {31'b0, bus_if.iomem_ready}, 32'h0);
    check("rst_rdata", bus_if.iomem_rdata, 32'h0);
    resetn = 1'b1;
    cycles(S + 2);
    for (int i = 0; i < 8; i++) access(3'(i), 4'h0, 32'h0, BASE);

    // OUT partial-strobe write and readback
    access(3'd0, 4'b0011, 32'h0000_05A5, BASE);
    check("out_5a5_pin", 32'(gpio_out), 32'h5A5);
    access(3'd0, 4'h0, 32'h0, BASE);

    // SET / CLR
    access(3'd0, 4'hF, 32'h0000_00F0, BASE);
    access(3'd3, 4'hF, 32'h0000_0003, BASE);
    check("set_pin", 32'(gpio_out), 32'h0F3);
    access(3'd4, 4'hF, 32'h0000_0030, BASE);
    check("clr_pin", 32'(gpio_out), 32'h0C3);
    access(3'd3, 4'h0, 32'h0, BASE);
    access(3'd4, 4'h0, 32'h0, BASE);

    // Width masking and address decode
    access(3'd1, 4'hF, 32'hFFFF_FFFF, BASE);
    check("oe_masked_pin", 32'(gpio_oe), 32'h7FF);
    access(3'd1, 4'h0, 32'h0, BASE);
    access(3'd0, 4'hF, 32'h0000_0000, 8'h02);
    check("wrong_sel_no_write", 32'(gpio_out), 32'h0C3);

    // Rising-edge interrupt latency and W1C
    access(3'd7, 4'hF, 32'h4, BASE);
    access(3'd5, 4'hF, 32'h4, BASE);
    gpio_in = W'(32'h4); old_p = m_pins; m_pins = 32'h4;
    for (int k = 0; k < S; k++) begin
      @(posedge clk); #1;
      check("irq_not_yet", {31'b0, irq}, 32'h0);
    end
    access(3'd6, 4'h0, 32'h0, BASE);  // sampled on the edge that sets status
    apply_edges(old_p, m_pins);
    check("irq_rise", {31'b0, irq}, 32'h1);
    access(3'd6, 4'h0, 32'h0, BASE);
    access(3'd6, 4'hF, 32'h4, BASE);
    check("irq_cleared", {31'b0, irq}, 32'h0);

    // Falling edge on bit 0 coinciding with its W1C: set wins
    gpio_in = W'(32'h5); old_p = m_pins; m_pins = 32'h5; cycles(S + 3); apply_edges(old_p, m_pins);
    gpio_in = W'(32'h4); old_p = m_pins; m_pins = 32'h4; cycles(S + 3); apply_edges(old_p, m_pins);
    access(3'd6, 4'h0, 32'h0, BASE);
    gpio_in = W'(32'h5); old_p = m_pins; m_pins = 32'h5; cycles(S + 3); apply_edges(old_p, m_pins);
    gpio_in = W'(32'h4); old_p = m_pins; m_pins = 32'h4; cycles(S);
    access(3'd6, 4'hF, 32'h1, BASE);
    apply_edges(old_p, m_pins);
    access(3'd6, 4'h0, 32'h0, BASE);
    check_pins_irq("directed");

    // Randomised traffic
    for (int it = 0; it < 250; it++) begin
      int unsigned op;
      op = $urandom_range(0, 4);
      if (op == 0) begin
        new_p = 32'(W'($urandom));
        gpio_in = W'(new_p); old_p = m_pins; m_pins = new_p;
        cycles(S + 3);
        apply_edges(old_p, new_p);
      end else begin
        logic [3:0] strb;
        logic [7:0] sel;
        strb = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
        sel  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : BASE;
        access(3'($urandom), strb, $urandom, sel);
      end
      check_pins_irq("rand");
    end

    // Reset in the middle of an access: no ready afterwards
    bus_if.iomem_addr  = {BASE, 19'h0, 3'd0, 2'b00};
    bus_if.iomem_wstrb = 4'h0;
    bus_if.iomem_valid = 1'b1;
    resetn = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("reset_mid_access_ready", {31'b0, bus_if.iomem_ready}, 32'h0);
    end
    bus_if.iomem_valid = 1'b0;

    // Pins high through reset must not raise status even with rising edges selected
    gpio_in = W'(32'h7FF); m_pins = 32'h7FF;
    cycles(3);
    resetn = 1'b1;
    access(3'd7, 4'hF, 32'h7FF, BASE);
    access(3'd5, 4'hF, 32'h7FF, BASE);
    cycles(8);
    access(3'd6, 4'h0, 32'h0, BASE);
    access(3'd2, 4'h0, 32'h0, BASE);
    check_pins_irq("post_reset");

    cycles(2);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/iomem_gpio.md
IOMEM_GPIO -- requirements
Module: iomem_gpio

Interface
REQ-001 SHALL have parameter WIDTH, default 11: number of GPIO pins, legal range 1..32.
REQ-002 SHALL have parameter BASE_SEL, default 8'h03: value matched against iomem_addr[31:24].
REQ-003 SHALL have parameter SYNC_STAGES, default 2: input synchroniser depth, legal range 2..3.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port resetn, input, 1 bit: reset is synchronous and active-low.
REQ-006 SHALL have port iomem_valid, input, 1 bit: request present.
REQ-007 SHALL have port iomem_ready, output, 1 bit: request complete.
REQ-008 SHALL have port iomem_wstrb, input, 4 bits: byte write strobes; all zero means read.
REQ-009 SHALL have port iomem_addr, input, 32 bits: byte address.
REQ-010 SHALL have port iomem_wdata, input, 32 bits: write data.
REQ-011 SHALL have port iomem_rdata, output, 32 bits: read data.
REQ-012 SHALL have port gpio_out, output, WIDTH bits: pin output values.
REQ-013 SHALL have port gpio_oe, output, WIDTH bits: per-pin output enable.
REQ-014 SHALL have port gpio_in, input, WIDTH bits: asynchronous pin inputs.
REQ-015 SHALL have port irq, output, 1 bit: level interrupt.

Function
REQ-016 SHALL select when iomem_valid && !iomem_ready && iomem_addr[31:24]==BASE_SEL; the register index is iomem_addr[4:2].
REQ-017 SHALL assert iomem_ready for exactly one cycle, in the cycle after selection, with iomem_rdata valid in that same cycle; iomem_ready SHALL stay 0 when not selected.
REQ-018 SHALL map registers by index: 0 OUT rw; 1 OE rw; 2 IN ro; 3 SET wo; 4 CLR wo; 5 IRQ_EN rw; 6 IRQ_STAT rw1c; 7 IRQ_EDGE rw (1 = rising, 0 = falling).
REQ-019 SHALL apply writes per byte lane under iomem_wstrb; bits at or above WIDTH are ignored on write and read as 0.
REQ-020 SHALL return the value each register held before the access, for reads and writes alike; SET and CLR SHALL read 0.
REQ-021 SHALL perform OUT |= wdata on a SET write and OUT &= ~wdata on a CLR write, masked by strobes, with no effect on other registers.
REQ-022 SHALL pass gpio_in through SYNC_STAGES flops; IN SHALL return the synchronised value.
REQ-023 SHALL hold a previous-sample register prev; an edge on bit i is sync[i]!=prev[i] in the direction selected by IRQ_EDGE[i].
REQ-024 SHALL latch a detected edge into IRQ_STAT[i] regardless of IRQ_EN[i].
REQ-025 SHALL clear IRQ_STAT[i] when a 1 is written to it; if an edge event occurs in the same cycle, set SHALL win.
REQ-026 SHALL drive irq as a register updated each cycle to |(IRQ_STAT & IRQ_EN), giving one cycle of latency after the status change.
REQ-027 SHALL apply a selected write to an unused index as a no-op and return rdata 0; it SHALL still complete with iomem_ready.
REQ-028 SHALL drive gpio_out and gpio_oe directly from the OUT and OE registers.

Reset
REQ-029 SHALL, while resetn=0, clear OUT, OE, IRQ_EN, IRQ_STAT, IRQ_EDGE, the synchroniser flops, prev, iomem_ready, iomem_rdata and irq to 0.
REQ-030 SHALL drop any in-flight request on reset, so that no iomem_ready pulse follows reset release for it.
REQ-031 SHALL suppress edge detection for the first SYNC_STAGES+1 cycles after reset release, so that pins already high do not set IRQ_STAT.

Structure
REQ-032 SHALL take its register index constants (OUT..IRQ_EDGE) from shared package gpio_pkg.
REQ-033 SHALL place the synchroniser, prev register and edge detection in sub-module gpio_sync_edge, parametrised by WIDTH and SYNC_STAGES, with outputs sync_val and edge_pulse.

Verification
REQ-034 SHALL verify: write OUT=0x5A5 with wstrb=4'b0011, then read OUT -> rdata 0x5A5, gpio_out=0x5A5, iomem_ready high one cycle after valid.
REQ-035 SHALL verify: OUT=0x0F0, SET 0x003, then CLR 0x030 -> gpio_out 0x0F3 then 0x0C3; SET/CLR reads return 0.
REQ-036 SHALL verify: IRQ_EDGE[2]=1, IRQ_EN[2]=1, raise gpio_in[2] -> IRQ_STAT bit 2 set SYNC_STAGES+1 cycles later, irq one cycle after that; write 0x4 to IRQ_STAT -> irq low.
REQ-037 SHALL verify: W1C of bit 0 issued in the same cycle as a new falling-edge event on bit 0 (IRQ_EDGE[0]=0) -> IRQ_STAT[0] remains 1.
REQ-038 SHALL verify: write 0xFFFFFFFF to OE with WIDTH=11 -> read 0x7FF; access with iomem_addr[31:24]=8'h02 -> no iomem_ready.
REQ-039 SHALL verify: gpio_in=0x7FF held during and after reset -> IRQ_STAT stays 0; reset asserted mid-access -> no iomem_ready.
